chmu_hot_report_queue: RTL and testbench

//  Sits directly downstream of the CHMU counter set. Captures its one-cycle hot-page

---
 rtl/chmu_pkg.sv | 20 ++
 rtl/chmu_recent_filter.sv | 58 +++++
 rtl/chmu_hot_report_queue.sv | 124 ++++++++++++
 tb/tb_chmu_hot_report_queue.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/chmu_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : chmu_pkg
//  Purpose  : Types and widths shared by the CHMU counter set and the
//             hot-page report path.
//  Revision : 1.0  initial release
// ============================================================================
package chmu_pkg;

    localparam int CHMU_ADDR_SIZE = 21;   // 4KB page index over an 8GB DPA space
    localparam int CHMU_CNT_SIZE  = 12;   // access count width of the counter set

    // One hot-page record as produced by the counter set.
    typedef struct packed {
        logic [CHMU_ADDR_SIZE-1:0] addr;
        logic [CHMU_CNT_SIZE-1:0]  cnt;
    } hot_rec_t;

endpackage : chmu_pkg
`default_nettype wire

// File: rtl/chmu_recent_filter.sv
`default_nettype none
// ============================================================================
//  Module   : chmu_recent_filter
//  Purpose  : Small fully associative set of recently reported page
//             addresses. Parallel single-cycle match, round-robin insertion,
//             bulk clear at epoch boundaries.
//  Revision : 1.0  initial release
// ============================================================================
module chmu_recent_filter #(
    parameter int ADDR_SIZE    = 21,
    parameter int FILT_ENTRIES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 insert,
    input  logic [ADDR_SIZE-1:0] addr,
    output logic                 hit
);

    // A single-entry filter still needs a one-bit pointer that stays at zero.
    localparam int PTR_W = (FILT_ENTRIES > 1) ? $clog2(FILT_ENTRIES) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FILT_ENTRIES - 1);

    logic [ADDR_SIZE-1:0]    entry_addr  [FILT_ENTRIES];
    logic [FILT_ENTRIES-1:0] entry_valid;
    logic [FILT_ENTRIES-1:0] entry_match;
    logic [PTR_W-1:0]        rr_ptr;

    generate
        for (genvar g = 0; g < FILT_ENTRIES; g++) begin : g_match
            assign entry_match[g] = entry_valid[g] && (entry_addr[g] == addr);
        end
    endgenerate

    assign hit = |entry_match;

    // Clear wipes valid bits and rewinds the pointer; insert fills the slot
    // under the pointer and advances it, wrapping at FILT_ENTRIES.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            entry_valid <= '0;
            rr_ptr      <= '0;
        end else if (insert) begin
            entry_valid[rr_ptr] <= 1'b1;
            rr_ptr              <= (rr_ptr == LAST_PTR) ? '0 : rr_ptr + PTR_W'(1);
        end
    end

    // Address storage needs no reset: it is only ever qualified by entry_valid.
    always_ff @(posedge clk) begin
        if (insert && !clear) begin
            entry_addr[rr_ptr] <= addr;
        end
    end

endmodule : chmu_recent_filter
`default_nettype wire

// File: rtl/chmu_hot_report_queue.sv
`default_nettype none
// ============================================================================
//  Module   : chmu_hot_report_queue
//  Purpose  : Captures non-backpressurable hot-page pulses from the CHMU
//             counter set, suppresses recently reported pages, buffers them
//             in a first-word-fall-through FIFO and presents them on a
//             valid/ready port. Keeps saturating drop/duplicate statistics.
//  Revision : 1.0  initial release
// ============================================================================
module chmu_hot_report_queue
    import chmu_pkg::*;
#(
    parameter int ADDR_SIZE    = CHMU_ADDR_SIZE,
    parameter int CNT_SIZE     = CHMU_CNT_SIZE,
    parameter int DEPTH        = 16,
    parameter int FILT_ENTRIES = 8,
    parameter int STAT_SIZE    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         epoch,
    input  logic                         in_valid,
    input  logic [ADDR_SIZE-1:0]         in_addr,
    input  logic [CNT_SIZE-1:0]          in_cnt,
    output logic                         out_valid,
    output logic [ADDR_SIZE-1:0]         out_addr,
    output logic [CNT_SIZE-1:0]          out_cnt,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [STAT_SIZE-1:0]         drop_cnt,
    output logic [STAT_SIZE-1:0]         dup_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int REC_W = ADDR_SIZE + CNT_SIZE;

    logic [REC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [OCC_W-1:0] occ_n;
    logic [REC_W-1:0] in_rec, head_n;
    logic             full, hit, live, pop, push, drop, dup;

    chmu_recent_filter #(
        .ADDR_SIZE    (ADDR_SIZE),
        .FILT_ENTRIES (FILT_ENTRIES)
    ) u_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (epoch),
        .insert (push),
        .addr   (in_addr),
        .hit    (hit)
    );

    // Classification uses start-of-cycle state; an epoch cycle swallows the pulse.
    always_comb begin
        in_rec = {in_addr, in_cnt};
        full   = (occupancy == OCC_W'(DEPTH));
        live   = in_valid && !epoch;
        pop    = out_valid && out_ready;
        dup    = live && hit;
        push   = live && !hit && (!full || pop);
        drop   = live && !hit && full && !pop;
    end

    // Next head: a record pushed into an otherwise empty FIFO is forwarded
    // directly, because the storage write lands on the same edge.
    always_comb begin
        rd_ptr_n = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        unique case ({push, pop})
            2'b10:   occ_n = occupancy + OCC_W'(1);
            2'b01:   occ_n = occupancy - OCC_W'(1);
            default: occ_n = occupancy;
        endcase
        head_n = (push && (rd_ptr_n == wr_ptr)) ? in_rec : mem[rd_ptr_n];
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_rec;
        end
    end

    // Pointers, occupancy and the registered head; head holds when empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_cnt   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= rd_ptr_n;
            occupancy <= occ_n;
            out_valid <= (occ_n != '0);
            if (occ_n != '0) begin
                {out_addr, out_cnt} <= head_n;
            end
        end
    end

    // Saturating statistics, restarted at each epoch boundary.
    always_ff @(posedge clk) begin
        if (!rst_n || epoch) begin
            drop_cnt <= '0;
            dup_cnt  <= '0;
        end else begin
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + STAT_SIZE'(1);
            end
            if (dup && (dup_cnt != '1)) begin
                dup_cnt <= dup_cnt + STAT_SIZE'(1);
            end
        end
    end

endmodule : chmu_hot_report_queue
`default_nettype wire

// File: tb/tb_chmu_hot_report_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_chmu_hot_report_queue
//  Purpose  : Directed self-checking bench for chmu_hot_report_queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_chmu_hot_report_queue;

    logic        clk;
    logic        rst_n;
    logic        epoch;
    logic        in_valid;
    logic [20:0] in_addr;
    logic [11:0] in_cnt;
    logic        out_valid;
    logic [20:0] out_addr;
    logic [11:0] out_cnt;
    logic        out_ready;
    logic [4:0]  occupancy;
    logic [15:0] drop_cnt;
    logic [15:0] dup_cnt;

    int nvec = 0;
    int nerr = 0;

    chmu_hot_report_queue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .epoch     (epoch),
        .in_valid  (in_valid),
        .in_addr   (in_addr),
        .in_cnt    (in_cnt),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_cnt   (out_cnt),
        .out_ready (out_ready),
        .occupancy (occupancy),
        .drop_cnt  (drop_cnt),
        .dup_cnt   (dup_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One cycle with the given input pulse and ready, then return inputs to idle.
    task automatic step(input logic v, input logic [20:0] a, input logic [11:0] c,
                        input logic rdy, input logic ep);
        in_valid  = v;
        in_addr   = a;
        in_cnt    = c;
        out_ready = rdy;
        epoch     = ep;
        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        epoch     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; epoch = 1'b0; in_valid = 1'b0;
        in_addr = '0; in_cnt = '0; out_ready = 1'b0;
        #1;
        do_reset();

        // Reset state
        check("rst_valid", out_valid, 0);
        check("rst_addr",  out_addr,  0);
        check("rst_occ",   occupancy, 0);
        check("rst_drop",  drop_cnt,  0);
        check("rst_dup",   dup_cnt,   0);

        // 1: push into empty FIFO, visible next cycle
        step(1, 21'h00ABC, 12'd20, 0, 0);
        check("t1_valid", out_valid, 1);
        check("t1_addr",  out_addr,  32'h00ABC);
        check("t1_cnt",   out_cnt,   20);
        check("t1_occ",   occupancy, 1);

        // 2: repeat of the same page 5 cycles later is suppressed
        for (int i = 0; i < 4; i++) step(0, '0, '0, 0, 0);
        step(1, 21'h00ABC, 12'd25, 0, 0);
        check("t2_occ", occupancy, 1);
        check("t2_dup", dup_cnt,   1);
        // push+pop at occupancy 1: head replaced, count unchanged
        step(1, 21'h00123, 12'd7, 1, 0);
        check("t2_pp_occ",  occupancy, 1);
        check("t2_pp_addr", out_addr,  32'h00123);
        check("t2_pp_cnt",  out_cnt,   7);
        // drain to empty: head holds last value
        step(0, '0, '0, 1, 0);
        check("t2_empty_valid", out_valid, 0);
        check("t2_empty_occ",   occupancy, 0);
        check("t2_hold_addr",   out_addr,  32'h00123);

        // 3: 18 distinct pages into a stalled FIFO
        do_reset();
        for (int i = 0; i < 18; i++) step(1, 21'h100 + 21'(i), 12'(i), 0, 0);
        check("t3_occ",  occupancy, 16);
        check("t3_drop", drop_cnt,  2);
        check("t3_dup",  dup_cnt,   0);
        check("t3_head", out_addr,  32'h100);
        step(0, '0, '0, 1, 0);
        check("t3_pop_occ",  occupancy, 15);
        check("t3_pop_head", out_addr,  32'h101);
        step(1, 21'h110, 12'd16, 0, 0);
        check("t3_re17_occ", occupancy, 16);
        check("t3_re17_dup", dup_cnt,   0);
        step(1, 21'h111, 12'd17, 1, 0);
        check("t3_re18_occ",  occupancy, 16);
        check("t3_re18_dup",  dup_cnt,   0);
        check("t3_re18_drop", drop_cnt,  2);
        check("t3_re18_head", out_addr,  32'h102);

        // 4: push into a full FIFO while popping is accepted
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 21'h200 + 21'(i), 12'(i), 0, 0);
        check("t4_full_occ", occupancy, 16);
        step(1, 21'h2F0, 12'd99, 1, 0);
        check("t4_occ",  occupancy, 16);
        check("t4_drop", drop_cnt,  0);
        check("t4_head", out_addr,  32'h201);
        for (int i = 0; i < 15; i++) step(0, '0, '0, 1, 0);
        check("t4_tail_occ",  occupancy, 1);
        check("t4_tail_addr", out_addr,  32'h2F0);
        check("t4_tail_cnt",  out_cnt,   99);

        // 5: nine pages through an eight-entry filter evict the first
        do_reset();
        for (int i = 0; i < 9; i++) step(1, 21'h300 + 21'(i), 12'(i), 0, 0);
        check("t5_occ9", occupancy, 9);
        step(1, 21'h300, 12'd50, 0, 0);
        check("t5_evict_occ", occupancy, 10);
        check("t5_evict_dup", dup_cnt,   0);
        step(1, 21'h308, 12'd51, 0, 0);
        check("t5_hit_occ", occupancy, 10);
        check("t5_hit_dup", dup_cnt,   1);

        // 6: epoch clears filter and stats, FIFO contents survive
        do_reset();
        step(1, 21'h400, 12'd1, 0, 0);
        step(1, 21'h401, 12'd2, 0, 0);
        step(1, 21'h402, 12'd3, 0, 0);
        step(1, 21'h401, 12'd4, 0, 0);
        check("t6_pre_dup", dup_cnt, 1);
        step(1, 21'h500, 12'd5, 0, 1);
        check("t6_ep_occ", occupancy, 3);
        check("t6_ep_dup", dup_cnt,   0);
        step(1, 21'h400, 12'd6, 0, 0);
        check("t6_repush_occ", occupancy, 4);
        check("t6_repush_dup", dup_cnt,   0);
        check("t6_d0", out_addr, 32'h400); step(0, '0, '0, 1, 0);
        check("t6_d1", out_addr, 32'h401); step(0, '0, '0, 1, 0);
        check("t6_d2", out_addr, 32'h402); step(0, '0, '0, 1, 0);
        check("t6_d3", out_addr, 32'h400);
        check("t6_d3_cnt", out_cnt, 6);
        check("t6_d3_occ", occupancy, 1);
        step(1, 21'h600, 12'd8, 0, 0);
        check("t6_pre_rst_occ", occupancy, 2);
        rst_n = 1'b0;
        step(0, '0, '0, 1, 0);
        rst_n = 1'b1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_occ",   occupancy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule : tb_chmu_hot_report_queue
`default_nettype wire
